// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: arbiter state encoding, requester id width and
// the helper that locates the read/write flag inside a request tag.
package sysbus_pkg;

    localparam int REQ_ID_W = 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WDATA,
        RESP
    } arb_state_t;

    // The top tag bit carries the direction: 1 = read, 0 = write.
    function automatic int tag_read_bit(input int tag_w);
        return tag_w - 1;
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Bundle of requester-side (p_*) and memory-side (m_*) Sysbus signals seen by
// the arbiter; master is the arbiter's view, slave is the surrounding system.
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic [1:0]                  p_bus_reqcyc;
    logic [2*BUS_DATA_WIDTH-1:0] p_bus_req;
    logic [2*BUS_TAG_WIDTH-1:0]  p_bus_reqtag;
    logic [1:0]                  p_bus_respack;
    logic [1:0]                  p_bus_reqack;
    logic [1:0]                  p_bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]   p_bus_resp;
    logic [BUS_TAG_WIDTH-1:0]    p_bus_resptag;

    logic                        m_bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]   m_bus_req;
    logic [BUS_TAG_WIDTH-1:0]    m_bus_reqtag;
    logic                        m_bus_respack;
    logic                        m_bus_reqack;
    logic                        m_bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]   m_bus_resp;
    logic [BUS_TAG_WIDTH-1:0]    m_bus_resptag;

    modport master (
        input  p_bus_reqcyc, p_bus_req, p_bus_reqtag, p_bus_respack,
        input  m_bus_reqack, m_bus_respcyc, m_bus_resp, m_bus_resptag,
        output p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
        output m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack
    );

    modport slave (
        output p_bus_reqcyc, p_bus_req, p_bus_reqtag, p_bus_respack,
        output m_bus_reqack, m_bus_respcyc, m_bus_resp, m_bus_resptag,
        input  p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
        input  m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack
    );

endinterface

// File: rtl/sysbus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever requester was not granted last.
module rr_arbiter2
    import sysbus_pkg::*;
(
    input  logic [1:0]          req,
    input  logic [REQ_ID_W-1:0] last_grant,
    output logic [REQ_ID_W-1:0] grant,
    output logic                valid
);

    assign valid = |req;
    assign grant = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the single Sysbus memory port between instruction fetch (0) and data
// access (1); one grant per burst, held until the last beat completes.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                clk,
    input  logic                reset,
    sysbus_arbiter_if.master    bus,
    output logic                arb_busy,
    output logic [REQ_ID_W-1:0] arb_grant
);

    localparam int         RD_BIT    = tag_read_bit(BUS_TAG_WIDTH);
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    arb_state_t          state_q, state_d;
    logic [REQ_ID_W-1:0] grant_q, grant_d;
    logic [REQ_ID_W-1:0] last_grant_q, last_grant_d;
    logic [3:0]          count_q, count_d;

    logic [REQ_ID_W-1:0]      pick;
    logic                     pick_valid;
    logic [1:0]               grant_mask;
    logic                     sel_reqcyc;
    logic                     sel_respack;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_tag;

    rr_arbiter2 u_rr (
        .req        (bus.p_bus_reqcyc),
        .last_grant (last_grant_q),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign grant_mask  = grant_q[0] ? 2'b10 : 2'b01;
    assign sel_reqcyc  = bus.p_bus_reqcyc[grant_q];
    assign sel_respack = bus.p_bus_respack[grant_q];
    assign sel_req     = grant_q[0] ? bus.p_bus_req[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                                    : bus.p_bus_req[BUS_DATA_WIDTH-1:0];
    assign sel_tag     = grant_q[0] ? bus.p_bus_reqtag[2*BUS_TAG_WIDTH-1:BUS_TAG_WIDTH]
                                    : bus.p_bus_reqtag[BUS_TAG_WIDTH-1:0];

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case statement can infer a latch.
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        count_d          = count_q;
        bus.m_bus_reqcyc  = 1'b0;
        bus.m_bus_req     = '0;
        bus.m_bus_reqtag  = '0;
        bus.m_bus_respack = 1'b0;
        bus.p_bus_reqack  = 2'b00;
        bus.p_bus_respcyc = 2'b00;
        bus.p_bus_resp    = '0;
        bus.p_bus_resptag = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR, WDATA: begin
                bus.m_bus_reqcyc = sel_reqcyc;
                bus.m_bus_req    = sel_req;
                bus.m_bus_reqtag = sel_tag;
                bus.p_bus_reqack = grant_mask & {2{bus.m_bus_reqack}};
                if (state_q == ADDR) begin
                    // A requester withdrawing before the address is taken
                    // leaves the round-robin history untouched.
                    if (!sel_reqcyc) begin
                        state_d = IDLE;
                    end else if (bus.m_bus_reqack) begin
                        count_d = '0;
                        state_d = sel_tag[RD_BIT] ? RESP : WDATA;
                    end
                end else if (sel_reqcyc && bus.m_bus_reqack) begin
                    if (count_q == LAST_BEAT) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            RESP: begin
                bus.p_bus_respcyc = grant_mask & {2{bus.m_bus_respcyc}};
                bus.m_bus_respack = sel_respack;
                bus.p_bus_resp    = bus.m_bus_resp;
                bus.p_bus_resptag = bus.m_bus_resptag;
                if (bus.m_bus_respcyc && sel_respack) begin
                    if (count_q == LAST_BEAT) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arb_busy  = (state_q != IDLE);
    assign arb_grant = grant_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from the same clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= '1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reset, single read, write burst,
// round-robin ties, response backpressure, ADDR abort and mid-burst reset.
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic arb_busy;
    logic arb_grant;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BEATS          (BEATS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .arb_busy  (arb_busy),
        .arb_grant (arb_grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic cyc, input logic [63:0] addr,
                           input logic [12:0] tag);
        bus.p_bus_reqcyc[i]           = cyc;
        bus.p_bus_req[i*DW +: DW]     = addr;
        bus.p_bus_reqtag[i*TW +: TW]  = tag;
    endtask

    // Deliver a full read burst with no stalls; mask is the expected respcyc.
    task automatic serve_read(input string name, input logic [1:0] mask, input logic [63:0] base);
        bus.m_bus_respcyc = 1'b1;
        bus.p_bus_respack = 2'b11;
        for (int i = 0; i < BEATS; i++) begin
            bus.m_bus_resp    = base + 64'(i);
            bus.m_bus_resptag = 13'h1000;
            #1;
            check({name, "_respcyc"}, 64'(bus.p_bus_respcyc), 64'(mask));
            check({name, "_resp"}, bus.p_bus_resp, base + 64'(i));
            check({name, "_reqack"}, 64'(bus.p_bus_reqack), 64'd0);
            check({name, "_busy"}, 64'(arb_busy), 64'd1);
            tick();
        end
        bus.m_bus_respcyc = 1'b0;
        #1;
        check({name, "_done_busy"}, 64'(arb_busy), 64'd0);
        check({name, "_done_reqack"}, 64'(bus.p_bus_reqack), 64'd0);
    endtask

    initial begin
        bus.p_bus_reqcyc  = '0;
        bus.p_bus_req     = '0;
        bus.p_bus_reqtag  = '0;
        bus.p_bus_respack = '0;
        bus.m_bus_reqack  = 1'b0;
        bus.m_bus_respcyc = 1'b0;
        bus.m_bus_resp    = '0;
        bus.m_bus_resptag = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(arb_busy), 64'd0);
        check("rst_grant", 64'(arb_grant), 64'd0);
        check("rst_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd0);
        check("rst_m_respack", 64'(bus.m_bus_respack), 64'd0);
        check("rst_p_reqack", 64'(bus.p_bus_reqack), 64'd0);
        check("rst_p_respcyc", 64'(bus.p_bus_respcyc), 64'd0);
        reset = 1'b1;

        // p0 read at 0x1000: one idle cycle of arbitration latency
        set_req(0, 1'b1, 64'h1000, 13'h1001);
        bus.m_bus_reqack = 1'b1;
        #1;
        check("t1_idle_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd0);
        check("t1_idle_p_reqack", 64'(bus.p_bus_reqack), 64'd0);
        tick();
        check("t1_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd1);
        check("t1_m_req", bus.m_bus_req, 64'h1000);
        check("t1_m_reqtag", 64'(bus.m_bus_reqtag), 64'h1001);
        check("t1_p_reqack", 64'(bus.p_bus_reqack), 64'b01);
        check("t1_grant", 64'(arb_grant), 64'd0);
        tick();
        set_req(0, 1'b0, 64'h0, 13'h0);
        bus.m_bus_reqack = 1'b0;
        serve_read("t1", 2'b01, 64'hA0);

        // p1 write at 0x4000, data 0..7; memory responses must be ignored
        set_req(1, 1'b1, 64'h4000, 13'h0005);
        bus.m_bus_reqack = 1'b1;
        tick();
        check("wr_grant", 64'(arb_grant), 64'd1);
        check("wr_addr", bus.m_bus_req, 64'h4000);
        check("wr_addr_reqack", 64'(bus.p_bus_reqack), 64'b10);
        tick();
        bus.m_bus_respcyc = 1'b1;
        bus.p_bus_respack = 2'b11;
        for (int i = 0; i < BEATS; i++) begin
            set_req(1, 1'b1, 64'(i), 13'h0005);
            #1;
            check("wr_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd1);
            check("wr_data", bus.m_bus_req, 64'(i));
            check("wr_p_reqack", 64'(bus.p_bus_reqack), 64'b10);
            check("wr_m_respack", 64'(bus.m_bus_respack), 64'd0);
            check("wr_p_respcyc", 64'(bus.p_bus_respcyc), 64'd0);
            tick();
        end
        bus.m_bus_respcyc = 1'b0;
        set_req(1, 1'b0, 64'h0, 13'h0);
        #1;
        check("wr_done_busy", 64'(arb_busy), 64'd0);

        // Simultaneous reads: last grant was p1, so p0 goes first
        set_req(0, 1'b1, 64'h2000, 13'h1002);
        set_req(1, 1'b1, 64'h3000, 13'h1013);
        tick();
        check("sim0_grant", 64'(arb_grant), 64'd0);
        check("sim0_m_req", bus.m_bus_req, 64'h2000);
        check("sim0_p_reqack", 64'(bus.p_bus_reqack), 64'b01);
        tick();
        serve_read("sim0", 2'b01, 64'hC0);
        tick();
        check("sim1_grant", 64'(arb_grant), 64'd1);
        check("sim1_m_req", bus.m_bus_req, 64'h3000);
        check("sim1_p_reqack", 64'(bus.p_bus_reqack), 64'b10);
        tick();
        set_req(1, 1'b0, 64'h0, 13'h0);
        serve_read("sim1", 2'b10, 64'hB0);
        tick();
        check("sim2_grant", 64'(arb_grant), 64'd0);
        check("sim2_m_req", bus.m_bus_req, 64'h2000);
        tick();
        set_req(0, 1'b0, 64'h0, 13'h0);

        // Backpressure: p0 holds respack low for 3 cycles at beat 4
        bus.m_bus_respcyc = 1'b1;
        bus.p_bus_respack = 2'b01;
        for (int i = 0; i < BEATS; i++) begin
            bus.m_bus_resp = 64'hD0 + 64'(i);
            if (i == 4) begin
                bus.p_bus_respack = 2'b00;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check("bp_stall_respack", 64'(bus.m_bus_respack), 64'd0);
                    check("bp_stall_respcyc", 64'(bus.p_bus_respcyc), 64'b01);
                    check("bp_stall_busy", 64'(arb_busy), 64'd1);
                    tick();
                end
                bus.p_bus_respack = 2'b01;
            end
            #1;
            check("bp_respack", 64'(bus.m_bus_respack), 64'd1);
            check("bp_resp", bus.p_bus_resp, 64'hD0 + 64'(i));
            check("bp_busy", 64'(arb_busy), 64'd1);
            tick();
        end
        bus.m_bus_respcyc = 1'b0;
        #1;
        check("bp_done_busy", 64'(arb_busy), 64'd0);

        // Aborts in ADDR: p0 then p1 withdraw; last grant stays p0
        bus.m_bus_reqack = 1'b0;
        set_req(0, 1'b1, 64'h5000, 13'h1005);
        tick();
        check("ab0_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd1);
        check("ab0_p_reqack", 64'(bus.p_bus_reqack), 64'd0);
        set_req(0, 1'b0, 64'h0, 13'h0);
        #1;
        check("ab0_drop_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd0);
        tick();
        check("ab0_idle", 64'(arb_busy), 64'd0);
        set_req(1, 1'b1, 64'h6000, 13'h1016);
        tick();
        check("ab1_grant", 64'(arb_grant), 64'd1);
        check("ab1_m_req", bus.m_bus_req, 64'h6000);
        set_req(1, 1'b0, 64'h0, 13'h0);
        tick();
        check("ab1_idle", 64'(arb_busy), 64'd0);
        set_req(0, 1'b1, 64'h7000, 13'h1007);
        set_req(1, 1'b1, 64'h8000, 13'h1018);
        bus.m_bus_reqack = 1'b1;
        tick();
        check("ab_last_kept_grant", 64'(arb_grant), 64'd1);
        check("ab_last_kept_req", bus.m_bus_req, 64'h8000);
        tick();

        // Reset at beat 5 of p1's read aborts it
        bus.m_bus_respcyc = 1'b1;
        bus.p_bus_respack = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.m_bus_resp = 64'hE0 + 64'(i);
            #1;
            check("mr_respcyc", 64'(bus.p_bus_respcyc), 64'b10);
            tick();
        end
        reset = 1'b0;
        tick();
        check("mr_busy", 64'(arb_busy), 64'd0);
        check("mr_grant", 64'(arb_grant), 64'd0);
        check("mr_m_reqcyc", 64'(bus.m_bus_reqcyc), 64'd0);
        check("mr_m_respack", 64'(bus.m_bus_respack), 64'd0);
        check("mr_p_respcyc", 64'(bus.p_bus_respcyc), 64'd0);
        check("mr_p_reqack", 64'(bus.p_bus_reqack), 64'd0);
        check("mr_p_resp", bus.p_bus_resp, 64'd0);
        bus.m_bus_respcyc = 1'b0;
        reset = 1'b1;
        tick();
        check("post_rst_grant", 64'(arb_grant), 64'd0);
        check("post_rst_m_req", bus.m_bus_req, 64'h7000);
        check("post_rst_busy", 64'(arb_busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Two-requester arbiter sharing the single Sysbus memory port between instruction fetch (requester 0) and data access (requester 1).
- Sits between the core/caches and the top-level bus pins.
- Grants one requester per transaction, round-robin, and holds the grant until the whole burst completes.
- Read = 1 address beat + BEATS response beats; write = 1 address beat + BEATS data beats.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp
BUS_TAG_WIDTH, 13, width of tags; bit [BUS_TAG_WIDTH-1] = 1 read, 0 write
BEATS, 8, data beats per burst (64-byte line); 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
p_bus_reqcyc  in  2  per-requester request valid, bit i = requester i
p_bus_req  in  2*BUS_DATA_WIDTH  packed address/write data, slice i = requester i
p_bus_reqtag  in  2*BUS_TAG_WIDTH  packed request tags
p_bus_respack  in  2  per-requester response accept
p_bus_reqack  out  2  per-requester request beat accepted
p_bus_respcyc  out  2  per-requester response beat valid
p_bus_resp  out  BUS_DATA_WIDTH  response data, broadcast to both requesters
p_bus_resptag  out  BUS_TAG_WIDTH  response tag, broadcast
m_bus_reqcyc  out  1  memory-side request valid
m_bus_req  out  BUS_DATA_WIDTH  memory-side address/data
m_bus_reqtag  out  BUS_TAG_WIDTH  memory-side tag
m_bus_respack  out  1  memory-side response accept
m_bus_reqack  in  1  memory accepted request beat
m_bus_respcyc  in  1  memory response beat valid
m_bus_resp  in  BUS_DATA_WIDTH  memory response data
m_bus_resptag  in  BUS_TAG_WIDTH  memory response tag
arb_busy  out  1  1 whenever state != IDLE
arb_grant  out  1  id of current or last granted requester

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, beat count=0, grant=0, last_grant=1 (requester 0 wins first).
  - All outputs are combinational from state, so after reset every output is 0.
  - Reset mid-burst aborts the transaction immediately; nothing is replayed.
- Handshakes:
  - Request beat transfers on m_bus_reqcyc && m_bus_reqack.
  - Response beat transfers on m_bus_respcyc && m_bus_respack.
- States: IDLE, ADDR, WDATA, RESP.
- IDLE:
  - Memory outputs are 0.
  - If any p_bus_reqcyc is set, register grant: the single requester if only one requests; if both, the one != last_grant. Go to ADDR.
  - One cycle of arbitration latency; no ack is ever given in IDLE.
- ADDR:
  - Mux the granted requester onto m_bus_reqcyc/req/reqtag.
  - p_bus_reqack[g] = m_bus_reqack; the other requester's ack is 0.
  - On handshake with read tag: count=0, go to RESP.
  - On handshake with write tag: count=0, go to WDATA.
  - If p_bus_reqcyc[g] drops before ack: go to IDLE, last_grant unchanged.
- WDATA:
  - Same pass-through as ADDR.
  - Count each handshake.
  - On the handshake with count==BEATS-1: last_grant<=g, go to IDLE.
- RESP:
  - p_bus_respcyc[g] = m_bus_respcyc; m_bus_respack = p_bus_respack[g].
  - p_bus_resp/resptag are driven from memory; the non-granted respcyc is 0.
  - Count each handshake.
  - On the handshake with count==BEATS-1: last_grant<=g, go to IDLE.
- Outside RESP: m_bus_respack=0 and memory responses are ignored.
- Stall rules:
  - The count does not advance on cycles without a handshake.
  - A requester may stall indefinitely by holding respack low.
- Non-granted requester: it may assert reqcyc at any time; it sees reqack=0 and respcyc=0 until granted.
- Back-to-back: after the final beat, IDLE lasts exactly one cycle before the next grant.
- Count is 4 bits and never wraps past BEATS-1.

Decomposition:
- Shared package sysbus_pkg holds:
  - the arb_state_t enum;
  - the REQ_ID_W constant;
  - a tag read-bit index function/constant alongside the existing Sysbus defines.
- Natural sub-module: rr_arbiter2. It is a combinational 2-way round-robin pick from (req[1:0], last_grant) producing grant id and a valid flag.
- The FSM, muxing and beat counter stay in sysbus_arbiter.

Test Plan:
- Reset and idle: reset=0 for 2 cycles, then p0 read request at 0x1000 with m_bus_reqack=1.
  - Expect m_bus_reqcyc=1 one cycle after the request; 8 resp beats routed only to p_bus_respcyc[0].
  - Expect arb_busy to fall the cycle after the 8th handshake.
- Simultaneous requests: p0 read 0x2000 and p1 read 0x3000 asserted in the same cycle, both held.
  - Expect p0 served first, then p1 (after one IDLE cycle), then p0 again if it re-requests.
  - p_bus_reqack[1] must stay 0 throughout p0's burst.
- p1 write at 0x4000 with data 0..7.
  - Expect 9 request handshakes forwarded (address + 8 data), m_bus_respack=0 throughout, then IDLE.
- Backpressure: during a p0 read, hold p_bus_respack[0]=0 for 3 cycles at beat 4.
  - Expect m_bus_respack=0 during the stall, count frozen, still exactly 8 beats delivered.
- Abort cases:
  - p0 drops reqcyc in ADDR before reqack: expect IDLE next cycle and last_grant unchanged.
  - Reset asserted at beat 5 of a read: expect all outputs 0 and state IDLE after that edge.
